// File: rtl/ram_burst_pkg.sv
// Shared constants and state encoding for the RAM burst master.
package ram_burst_pkg;

  // Read buffer depth; a power of two so the pointers wrap naturally.
  localparam int unsigned CBufDepth = 4;
  localparam int unsigned CPtrLen   = $clog2(CBufDepth);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr   = 2'd1,
    StRd   = 2'd2,
    StFin  = 2'd3
  } state_e;

endpackage

// File: rtl/ram_burst_rdbuf.sv
// Small synchronous FIFO holding read words plus their end-of-burst marker.
module ram_burst_rdbuf
  import ram_burst_pkg::*;
#(
  parameter int unsigned Width = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             push_last_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             last_o,
  output logic             empty_o,
  output logic [CPtrLen:0] occ_o
);

  logic [Width-1:0]     data_q [CBufDepth];
  logic [Width-1:0]     data_d [CBufDepth];
  logic [CBufDepth-1:0] last_q, last_d;
  logic [CPtrLen-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CPtrLen-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CPtrLen:0]     occ_q, occ_d;

  // Next state: write at the tail, advance pointers, track occupancy.
  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) begin
      data_d[wr_ptr_q] = push_data_i;
      last_d[wr_ptr_q] = push_last_i;
      wr_ptr_d         = wr_ptr_q + CPtrLen'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + CPtrLen'(1);
    end
    if (push_i && !pop_i) begin
      occ_d = occ_q + (CPtrLen + 1)'(1);
    end else if (!push_i && pop_i) begin
      occ_d = occ_q - (CPtrLen + 1)'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q   <= '{default: '0};
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      data_q   <= data_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Head outputs are zeroed while empty so stale words never leak out.
  always_comb begin
    empty_o = (occ_q == '0);
    occ_o   = occ_q;
    data_o  = empty_o ? '0 : data_q[rd_ptr_q];
    last_o  = ~empty_o & last_q[rd_ptr_q];
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: commands become per-word strobes,
// write data arrives on a valid/ready stream, read data leaves through a small buffer.
module ram_burst_master
  import ram_burst_pkg::*;
#(
  parameter int unsigned CAddrLen = 13,
  parameter int unsigned CDataLen = 128,
  parameter int unsigned CLenLen  = 8
) (
  input  logic                AClkH,
  input  logic                AResetHN,
  input  logic                AClkHEn,
  input  logic                ACmdValid,
  output logic                ACmdReady,
  input  logic                ACmdWr,
  input  logic [CAddrLen-1:0] ACmdAddr,
  input  logic [CLenLen-1:0]  ACmdLen,
  input  logic                AWdValid,
  output logic                AWdReady,
  input  logic [CDataLen-1:0] AWdData,
  output logic                ARdValid,
  input  logic                ARdReady,
  output logic [CDataLen-1:0] ARdData,
  output logic                ARdLast,
  output logic                ABusy,
  output logic                ADone,
  output logic [CAddrLen-1:0] ARamAddr,
  output logic [CDataLen-1:0] ARamMosi,
  input  logic [CDataLen-1:0] ARamMiso,
  output logic                ARamWrEn,
  output logic                ARamRdEn
);

  localparam logic [CPtrLen:0] CBufDepthW = (CPtrLen + 1)'(CBufDepth);

  state_e              state_q, state_d;
  logic [CAddrLen-1:0] addr_q, addr_d;
  logic [CLenLen-1:0]  cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;

  logic                cmd_hs, wd_hs, rd_issue, rd_pop, buf_push;
  logic                buf_empty, buf_last, cnt_zero;
  logic [CDataLen-1:0] buf_data;
  logic [CPtrLen:0]    buf_occ, occ_used;

  assign cnt_zero = (cnt_q == '0);
  // Slots already claimed: buffered words plus the one the RAM is returning.
  assign occ_used = buf_occ + {{CPtrLen{1'b0}}, inflight_q};

  // Outputs and handshake qualifiers; strobes stay combinational and ignore AClkHEn.
  always_comb begin
    ACmdReady = (state_q == StIdle) & AClkHEn;
    AWdReady  = (state_q == StWr) & AClkHEn;
    ARamWrEn  = (state_q == StWr) & AWdValid;
    ARamRdEn  = (state_q == StRd) & (occ_used < CBufDepthW);
    ARamAddr  = addr_q;
    ARamMosi  = (state_q == StWr) ? AWdData : '0;
    ARdValid  = ~buf_empty;
    ARdData   = buf_data;
    ARdLast   = buf_last;
    cmd_hs    = ACmdValid & ACmdReady;
    wd_hs     = AWdValid & AWdReady;
    rd_issue  = ARamRdEn & AClkHEn;
    rd_pop    = ARdValid & ARdReady & AClkHEn;
    buf_push  = inflight_q & AClkHEn;
    // Write bursts finish in their single Fin cycle; read bursts on the last pop.
    ADone     = ((state_q == StFin) & wr_q & AClkHEn) | (rd_pop & buf_last);
    ABusy     = (state_q != StIdle) | ~buf_empty;
  end

  // Next-state logic; nothing moves on disabled cycles.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    wr_d            = wr_q;
    inflight_d      = inflight_q;
    inflight_last_d = inflight_last_q;
    if (AClkHEn) begin
      inflight_d      = rd_issue;
      inflight_last_d = rd_issue & cnt_zero;
      unique case (state_q)
        StIdle: begin
          if (cmd_hs) begin
            addr_d  = ACmdAddr;
            cnt_d   = ACmdLen;
            wr_d    = ACmdWr;
            state_d = ACmdWr ? StWr : StRd;
          end
        end
        StWr: begin
          if (wd_hs) begin
            addr_d = addr_q + CAddrLen'(1);
            cnt_d  = cnt_q - CLenLen'(1);
            if (cnt_zero) state_d = StFin;
          end
        end
        StRd: begin
          if (rd_issue) begin
            addr_d = addr_q + CAddrLen'(1);
            cnt_d  = cnt_q - CLenLen'(1);
            if (cnt_zero) state_d = StFin;
          end
        end
        StFin: begin
          // The last-marked pop also leaves the buffer empty with nothing in flight.
          if (wr_q || (rd_pop && buf_last)) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers; reset aborts any burst.
  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      cnt_q           <= '0;
      wr_q            <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      wr_q            <= wr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  ram_burst_rdbuf #(
    .Width (CDataLen)
  ) u_rdbuf (
    .clk_i       (AClkH),
    .rst_ni      (AResetHN),
    .push_i      (buf_push),
    .push_data_i (ARamMiso),
    .push_last_i (inflight_last_q),
    .pop_i       (rd_pop),
    .data_o      (buf_data),
    .last_o      (buf_last),
    .empty_o     (buf_empty),
    .occ_o       (buf_occ)
  );

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: behavioural RAM, reference memory and per-cycle scoreboard.
module tb_ram_burst_master;

  typedef struct packed {
    logic [12:0]  a;
    logic [127:0] d;
  } wr_t;

  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } rd_t;

  logic         AClkH = 1'b0;
  logic         AResetHN;
  logic         AClkHEn = 1'b1;
  logic         ACmdValid, ACmdReady, ACmdWr;
  logic [12:0]  ACmdAddr;
  logic [7:0]   ACmdLen;
  logic         AWdValid, AWdReady;
  logic [127:0] AWdData;
  logic         ARdValid, ARdReady, ARdLast, ABusy, ADone;
  logic [127:0] ARdData;
  logic [12:0]  ARamAddr;
  logic [127:0] ARamMosi;
  logic [127:0] ARamMiso = '0;
  logic         ARamWrEn, ARamRdEn;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_issue_cnt = 0;
  logic toggle_en = 1'b0;
  logic wr_fin_pending = 1'b0;

  logic [127:0] ram [8192];
  logic [127:0] ref_mem [8192];

  wr_t exp_wr[$];
  rd_t exp_rd[$];
  logic [12:0]  wr_log_a[$];
  int           wr_log_c[$];
  logic [127:0] rd_log_d[$];
  logic         rd_log_l[$];
  int           rd_log_c[$];
  int           done_c[$];

  ram_burst_master dut (
    .AClkH     (AClkH),
    .AResetHN  (AResetHN),
    .AClkHEn   (AClkHEn),
    .ACmdValid (ACmdValid),
    .ACmdReady (ACmdReady),
    .ACmdWr    (ACmdWr),
    .ACmdAddr  (ACmdAddr),
    .ACmdLen   (ACmdLen),
    .AWdValid  (AWdValid),
    .AWdReady  (AWdReady),
    .AWdData   (AWdData),
    .ARdValid  (ARdValid),
    .ARdReady  (ARdReady),
    .ARdData   (ARdData),
    .ARdLast   (ARdLast),
    .ABusy     (ABusy),
    .ADone     (ADone),
    .ARamAddr  (ARamAddr),
    .ARamMosi  (ARamMosi),
    .ARamMiso  (ARamMiso),
    .ARamWrEn  (ARamWrEn),
    .ARamRdEn  (ARamRdEn)
  );

  always #5 AClkH = ~AClkH;

  always @(posedge AClkH) cyc <= cyc + 1;

  // Enable driver: constant 1, or alternating when toggle_en is set.
  always @(posedge AClkH) begin
    #1;
    AClkHEn = toggle_en ? ~AClkHEn : 1'b1;
  end

  // Behavioural RAM: registered address, one-cycle latency, zero-gated read data.
  always @(posedge AClkH) begin
    if (AClkHEn) begin
      if (ARamWrEn) ram[ARamAddr] <= ARamMosi;
      ARamMiso <= ARamRdEn ? ram[ARamAddr] : '0;
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard: every cycle, handshakes against the expected streams, ADone against the model.
  always @(negedge AClkH) begin
    logic exp_done;
    wr_t  we;
    rd_t  re;
    exp_done = 1'b0;
    if (!AResetHN) begin
      wr_fin_pending = 1'b0;
    end else begin
      if (ARamRdEn || ARamWrEn) chk("strobe_excl", 128'(ARamRdEn & ARamWrEn), 128'(0));
      if (AClkHEn) begin
        if (ARamRdEn) rd_issue_cnt++;
        if (wr_fin_pending) begin
          exp_done       = 1'b1;
          wr_fin_pending = 1'b0;
        end
        if (AWdValid && AWdReady) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected addr=%0h (cycle %0d)", ARamAddr, cyc);
          end else begin
            we = exp_wr.pop_front();
            chk("wr_strobe", 128'(ARamWrEn), 128'(1));
            chk("wr_addr", 128'(ARamAddr), 128'(we.a));
            chk("wr_data", ARamMosi, we.d);
            wr_log_a.push_back(ARamAddr);
            wr_log_c.push_back(cyc);
            if (exp_wr.size() == 0) wr_fin_pending = 1'b1;
          end
        end
        if (ARdValid && ARdReady) begin
          if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected data=%0h (cycle %0d)", ARdData, cyc);
          end else begin
            re = exp_rd.pop_front();
            chk("rd_data", ARdData, re.d);
            chk("rd_last", 128'(ARdLast), 128'(re.last));
            rd_log_d.push_back(ARdData);
            rd_log_l.push_back(ARdLast);
            rd_log_c.push_back(cyc);
            if (re.last) exp_done = 1'b1;
          end
        end
      end else begin
        chk("cmd_ready_gated", 128'(ACmdReady), 128'(0));
        chk("wd_ready_gated", 128'(AWdReady), 128'(0));
      end
      chk("done", 128'(ADone), 128'(exp_done));
      if (ADone) done_c.push_back(cyc);
    end
  end

  task automatic clr_logs();
    wr_log_a.delete();
    wr_log_c.delete();
    rd_log_d.delete();
    rd_log_l.delete();
    rd_log_c.delete();
    done_c.delete();
  endtask

  task automatic do_wr(input logic [12:0] a, input logic [7:0] len, input logic [127:0] base);
    int   n;
    int   i;
    int   g;
    logic chs;
    logic whs;
    wr_t  e;
    n = int'(len) + 1;
    for (int k = 0; k < n; k++) begin
      e.a = a + 13'(k);
      e.d = base + 128'(k);
      ref_mem[e.a] = e.d;
      exp_wr.push_back(e);
    end
    @(posedge AClkH); #1;
    ACmdValid = 1'b1;
    ACmdWr    = 1'b1;
    ACmdAddr  = a;
    ACmdLen   = len;
    AWdValid  = 1'b1;
    AWdData   = base;
    i = 0;
    g = 0;
    while (i < n && g < 500) begin
      @(negedge AClkH);
      chs = ACmdValid && ACmdReady;
      whs = AWdValid && AWdReady;
      @(posedge AClkH); #1;
      if (chs) ACmdValid = 1'b0;
      if (whs) begin
        i++;
        AWdData = base + 128'(i);
        if (i == n) AWdValid = 1'b0;
      end
      g++;
    end
    ACmdValid = 1'b0;
    AWdValid  = 1'b0;
    if (i < n) begin
      checks++;
      errors++;
      $display("FAIL wr_burst_timeout words=%0d of %0d", i, n);
    end
  endtask

  task automatic start_rd(input logic [12:0] a, input logic [7:0] len);
    int   g;
    logic hs;
    rd_t  e;
    for (int k = 0; k <= int'(len); k++) begin
      e.d    = ref_mem[a + 13'(k)];
      e.last = (k == int'(len));
      exp_rd.push_back(e);
    end
    @(posedge AClkH); #1;
    ACmdValid = 1'b1;
    ACmdWr    = 1'b0;
    ACmdAddr  = a;
    ACmdLen   = len;
    g  = 0;
    hs = 1'b0;
    while (!hs && g < 200) begin
      @(negedge AClkH);
      hs = ACmdValid && ACmdReady;
      @(posedge AClkH); #1;
      g++;
    end
    ACmdValid = 1'b0;
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL rd_cmd_accept_timeout addr=%0h", a);
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((ABusy || exp_wr.size() != 0 || exp_rd.size() != 0) && g < 2000) begin
      @(posedge AClkH); #1;
      g++;
    end
    chk("idle_busy", 128'(ABusy), 128'(0));
    chk("idle_exp_rd_left", 128'(exp_rd.size()), 128'(0));
    chk("idle_exp_wr_left", 128'(exp_wr.size()), 128'(0));
  endtask

  initial begin
    logic [12:0] wrap_a [4];
    int          issues0;
    wrap_a = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};

    AResetHN  = 1'b0;
    ACmdValid = 1'b0;
    ACmdWr    = 1'b0;
    ACmdAddr  = '0;
    ACmdLen   = '0;
    AWdValid  = 1'b0;
    AWdData   = '0;
    ARdReady  = 1'b0;
    #1;
    chk("rst_cmd_ready", 128'(ACmdReady), 128'(1));
    chk("rst_rd_valid", 128'(ARdValid), 128'(0));
    chk("rst_busy", 128'(ABusy), 128'(0));
    chk("rst_done", 128'(ADone), 128'(0));
    chk("rst_wr_en", 128'(ARamWrEn), 128'(0));
    chk("rst_rd_en", 128'(ARamRdEn), 128'(0));
    chk("rst_ram_addr", 128'(ARamAddr), 128'(0));
    chk("rst_wd_ready", 128'(AWdReady), 128'(0));
    repeat (2) @(posedge AClkH);
    #1 AResetHN = 1'b1;

    // Write 0x010..0x013 with A0..A3.
    clr_logs();
    do_wr(13'h010, 8'd3, 128'hA0);
    wait_idle();
    chk("t1_wr_count", 128'(wr_log_a.size()), 128'(4));
    if (wr_log_a.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t1_wr_addr", 128'(wr_log_a[i]), 128'(13'h010 + 13'(i)));
      chk("t1_wr_consecutive", 128'(wr_log_c[3] - wr_log_c[0]), 128'(3));
      chk("t1_done_count", 128'(done_c.size()), 128'(1));
      if (done_c.size() == 1) chk("t1_done_cycle", 128'(done_c[0]), 128'(wr_log_c[3] + 1));
    end

    // Read back with the consumer always ready.
    clr_logs();
    ARdReady = 1'b1;
    start_rd(13'h010, 8'd3);
    wait_idle();
    chk("t2_rd_count", 128'(rd_log_d.size()), 128'(4));
    if (rd_log_d.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_rd_data", rd_log_d[i], 128'hA0 + 128'(i));
        chk("t2_rd_last", 128'(rd_log_l[i]), 128'(i == 3));
      end
      chk("t2_rd_consecutive", 128'(rd_log_c[3] - rd_log_c[0]), 128'(3));
      chk("t2_done_count", 128'(done_c.size()), 128'(1));
      if (done_c.size() == 1) chk("t2_done_cycle", 128'(done_c[0]), 128'(rd_log_c[3]));
    end

    // Address wrap at the top of the space, then read it back.
    clr_logs();
    do_wr(13'h1FFE, 8'd3, 128'hB0);
    wait_idle();
    chk("t4_wr_count", 128'(wr_log_a.size()), 128'(4));
    if (wr_log_a.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("t4_wrap_addr", 128'(wr_log_a[i]), 128'(wrap_a[i]));
    end
    start_rd(13'h1FFE, 8'd3);
    wait_idle();

    // 16-word read against a stalled consumer.
    do_wr(13'h200, 8'd15, 128'h300);
    wait_idle();
    clr_logs();
    ARdReady = 1'b0;
    issues0  = rd_issue_cnt;
    start_rd(13'h200, 8'd15);
    repeat (20) @(posedge AClkH);
    #1;
    chk("t3_stall_issues_le4", 128'((rd_issue_cnt - issues0) <= 4), 128'(1));
    chk("t3_stall_no_pop", 128'(rd_log_d.size()), 128'(0));
    chk("t3_stall_valid", 128'(ARdValid), 128'(1));
    ARdReady = 1'b1;
    wait_idle();
    chk("t3_rd_count", 128'(rd_log_d.size()), 128'(16));
    if (rd_log_d.size() == 16) chk("t3_last_word", rd_log_d[15], 128'h30F);

    // Clock enable toggling every cycle.
    clr_logs();
    toggle_en = 1'b1;
    do_wr(13'h100, 8'd5, 128'hC0);
    wait_idle();
    start_rd(13'h100, 8'd5);
    wait_idle();
    toggle_en = 1'b0;
    chk("t5_wr_count", 128'(wr_log_a.size()), 128'(6));
    if (wr_log_a.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t5_wr_addr", 128'(wr_log_a[i]), 128'(13'h100 + 13'(i)));
    end
    chk("t5_rd_count", 128'(rd_log_d.size()), 128'(6));
    if (rd_log_d.size() == 6) chk("t5_rd_first", rd_log_d[0], 128'hC0);
    chk("t5_done_count", 128'(done_c.size()), 128'(2));
    repeat (2) @(posedge AClkH);
    #1;

    // Reset in the middle of a read burst with two words buffered.
    clr_logs();
    ARdReady = 1'b0;
    start_rd(13'h200, 8'd7);
    repeat (3) @(posedge AClkH);
    #2;
    chk("t6_pre_valid", 128'(ARdValid), 128'(1));
    AResetHN = 1'b0;
    #1;
    chk("t6_rst_valid", 128'(ARdValid), 128'(0));
    chk("t6_rst_busy", 128'(ABusy), 128'(0));
    chk("t6_rst_cmd_ready", 128'(ACmdReady), 128'(1));
    chk("t6_rst_done", 128'(ADone), 128'(0));
    exp_rd.delete();
    @(posedge AClkH);
    #1 AResetHN = 1'b1;
    chk("t6_no_done", 128'(done_c.size()), 128'(0));
    ARdReady = 1'b1;
    start_rd(13'h010, 8'd3);
    wait_idle();
    chk("t6_rd_count", 128'(rd_log_d.size()), 128'(4));
    if (rd_log_d.size() == 4) chk("t6_rd_last_word", rd_log_d[3], 128'hA3);
    chk("t6_done_count", 128'(done_c.size()), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
Initiator for the team's single-port synchronous RAM port: turns burst commands (start address, length, direction) into per-word RAM strobes. Write data comes in on a valid/ready stream; read data goes out on a valid/ready stream. Sits between DMA/cache-fill logic and a RAM instance that has a registered address, one-cycle read latency and zero-gated read data. Absorbs RAM read latency against consumer back-pressure with a small read buffer.

Parameters:
CAddrLen, 13, RAM word-address width; addresses wrap modulo 2^CAddrLen.
CDataLen, 128, data word width.
CLenLen, 8, burst length field width; burst words = ACmdLen+1.

Ports:
AClkH  in  1  clock.
AResetHN  in  1  asynchronous, active-low reset.
AClkHEn  in  1  clock enable shared with the RAM; no state changes when 0.
ACmdValid  in  1  command valid.
ACmdReady  out  1  command accepted (Idle & AClkHEn).
ACmdWr  in  1  1=write burst, 0=read burst.
ACmdAddr  in  CAddrLen  start word address.
ACmdLen  in  CLenLen  words-1.
AWdValid  in  1  write data valid.
AWdReady  out  1  write data taken.
AWdData  in  CDataLen  write word.
ARdValid  out  1  read word available.
ARdReady  in  1  consumer ready.
ARdData  out  CDataLen  read word.
ARdLast  out  1  marks the final word of the burst.
ABusy  out  1  state != Idle or buffer not empty.
ADone  out  1  one-cycle completion pulse.
ARamAddr  out  CAddrLen  RAM address.
ARamMosi  out  CDataLen  RAM write data.
ARamMiso  in  CDataLen  RAM read data, valid the enabled cycle after a read strobe.
ARamWrEn  out  1  RAM write strobe.
ARamRdEn  out  1  RAM read strobe.

Behaviour:
- Reset: state Idle; buffer empty; in-flight flag 0. All outputs 0 except ACmdReady = AClkHEn. Applies asynchronously and aborts any burst mid-operation, with no ADone.
- Handshakes complete only on cycles with AClkHEn=1: Valid & Ready & AClkHEn. ACmdReady and AWdReady are gated with AClkHEn. Registers hold when AClkHEn=0.
- States: Idle, Wr, Rd, Fin.
- Idle: on command handshake, latch address and remaining count (ACmdLen). Go to Wr if ACmdWr, else Rd.
- Wr:
  - AWdReady=1.
  - ARamWrEn = AWdValid; ARamAddr = current address; ARamMosi = AWdData; all combinational.
  - Each accepted word increments the address (mod 2^CAddrLen) and decrements the count.
  - After the last word, go to Fin. Fin lasts one enabled cycle, during which the RAM commits the last word; ADone is pulsed in that cycle, then the block returns to Idle.
  - AWdValid low: no strobe; address and count held.
- Rd:
  - ARamRdEn=1 when occ + inflight < CBufDepth, using the values at the start of the cycle.
  - The in-flight flag is set on an issue. The next enabled cycle pushes ARamMiso into the buffer and clears the flag, unless a new issue sets it again.
  - Issue order and address stepping are as in Wr.
  - After the last issue, go to Fin. Stay in Fin until the buffer is empty and nothing is in flight.
  - ADone pulses on the cycle the last word handshakes.
  - Throughput is 1 word/cycle when ARdReady is held high.
- Read buffer: FIFO of CBufDepth=4 entries. ARdData is taken from the head. ARdLast is stored per entry, set for the final word. A simultaneous push and pop keeps occupancy unchanged.
- ARamMiso is ignored unless the in-flight flag is set.
- ARamRdEn and ARamWrEn are never both 1. Strobes are combinational and held stable while AClkHEn=0.
- A write immediately followed by a read of the same address returns the new data, because the RAM orders it.

Decomposition:
- Package ram_burst_pkg holds:
  - CBufDepth = 4 and its pointer width.
  - State encoding for Idle, Wr, Rd, Fin.
- Sub-module ram_burst_rdbuf: synchronous FIFO with data+last, depth CBufDepth, push/pop, occupancy output, async reset.

Test Plan:
- Write burst, Addr=0x010, Len=3, data 0xA0..0xA3, AWdValid constant → ARamWrEn on 4 consecutive cycles at 0x010..0x013; ADone exactly once, 1 cycle after the last strobe.
- Read back the same range with ARdReady=1 → ARdData 0xA0..0xA3 on consecutive cycles; ARdLast only on 0xA3; ADone with the 0xA3 handshake.
- Read 16 words with ARdReady=0 for 20 cycles → at most 4 ARamRdEn pulses; then release → remaining words arrive in order with no loss or duplication.
- Write Addr=0x1FFE, Len=3 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- AClkHEn toggled 1/0 every cycle during read and write bursts → same data/address sequences as with AClkHEn=1; no handshake counted on disabled cycles.
- Assert AResetHN low mid read burst with 2 words buffered → ARdValid=0 immediately, state Idle, no ADone; a new command is accepted after release.
